// File: rtl/maquina_vendas_param.sv
// Vending machine controller: coin credit, keypad product code,
// dispense with change, full refund on cancel or inactivity.
module maquina_vendas_param #(
  parameter int CODE_DIGITS     = 2,
  parameter int CREDIT_W        = 8,
  parameter int TIMEOUT         = 50000000,
  parameter int DISPENSE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     coin_valid,
  input  logic [CREDIT_W-1:0]      coin_value,
  input  logic                     key_valid,
  input  logic [3:0]               key_code,
  input  logic [CREDIT_W-1:0]      price,
  input  logic                     product_exists,
  output logic [4*CODE_DIGITS-1:0] product_code,
  output logic [CREDIT_W-1:0]      credit,
  output logic [2:0]               state,
  output logic                     dispense,
  output logic                     change_valid,
  output logic [CREDIT_W-1:0]      change_amount,
  output logic                     refund,
  output logic                     error
);

  localparam int CW = 4 * CODE_DIGITS;
  localparam int NW = $clog2(CODE_DIGITS + 1);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int DW = (DISPENSE_CYCLES > 2) ? $clog2(DISPENSE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CODE   = 3'd1,
    S_PAY    = 3'd2,
    S_DISP   = 3'd3,
    S_REFUND = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CW-1:0]       code_q, code_d;
  logic [NW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [DW-1:0]       disp_q, disp_d;
  logic [CREDIT_W-1:0] chg_q, chg_d;
  logic                chg_v_q, chg_v_d;
  logic                err_q, err_d;

  logic                is_digit, is_cancel, is_enter;
  logic                active, coin_en, coin_ok, coin_ovf;
  logic                code_full, timeout, cancel, digit_ok;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] credit_acc;

  // Decode strobes and the credit including any coin accepted this cycle
  always_comb begin
    is_digit   = key_valid && (key_code <= 4'd9);
    is_cancel  = key_valid && (key_code == 4'd10);
    is_enter   = key_valid && (key_code == 4'd11);
    active     = (state_q == S_CODE) || (state_q == S_PAY);
    coin_en    = coin_valid && (active || state_q == S_IDLE);
    sum        = {1'b0, credit_q} + {1'b0, coin_value};
    coin_ovf   = coin_en && sum[CREDIT_W];
    coin_ok    = coin_en && !sum[CREDIT_W];
    credit_acc = coin_ok ? sum[CREDIT_W-1:0] : credit_q;
    code_full  = (cnt_q == NW'(CODE_DIGITS));
    timeout    = active && (timer_q == TW'(TIMEOUT - 1));
    cancel     = is_cancel || timeout;
    digit_ok   = is_digit && !code_full &&
                 (state_q == S_IDLE || state_q == S_CODE);
  end

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    credit_d = credit_acc;
    code_d   = code_q;
    cnt_d    = cnt_q;
    disp_d   = disp_q;
    chg_d    = chg_q;
    chg_v_d  = 1'b0;
    err_d    = coin_ovf;
    unique case (state_q)
      S_IDLE, S_CODE, S_PAY: begin
        if (cancel) begin
          code_d = '0;
          cnt_d  = '0;
          if (credit_acc != '0) begin
            state_d  = S_REFUND;
            chg_d    = credit_acc;
            chg_v_d  = 1'b1;
            credit_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (digit_ok) begin
          code_d  = (code_q << 4) | CW'(key_code);
          cnt_d   = cnt_q + NW'(1);
          state_d = S_CODE;
        end else if (is_enter && code_full && state_q == S_CODE) begin
          if (product_exists) begin
            state_d = S_PAY;
          end else begin
            err_d   = 1'b1;
            code_d  = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end else if (state_q == S_PAY && credit_q >= price) begin
          state_d  = S_DISP;
          chg_d    = credit_acc - price;
          chg_v_d  = (credit_acc != price);
          credit_d = '0;
          disp_d   = '0;
        end
      end
      S_DISP: begin
        if (disp_q == DW'(DISPENSE_CYCLES - 1)) begin
          state_d = S_IDLE;
          code_d  = '0;
          cnt_d   = '0;
        end else begin
          disp_d = disp_q + DW'(1);
        end
      end
      S_REFUND: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Inactivity timer: restarts on any activity or state change
  always_comb begin
    if (!active || state_d != state_q || coin_ok || digit_ok)
      timer_d = '0;
    else
      timer_d = timer_q + TW'(1);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      code_q   <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      disp_q   <= '0;
      chg_q    <= '0;
      chg_v_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      disp_q   <= disp_d;
      chg_q    <= chg_d;
      chg_v_q  <= chg_v_d;
      err_q    <= err_d;
    end
  end

  assign product_code  = code_q;
  assign credit        = credit_q;
  assign state         = state_q;
  assign dispense      = (state_q == S_DISP);
  assign refund        = (state_q == S_REFUND);
  assign change_valid  = chg_v_q;
  assign change_amount = chg_q;
  assign error         = err_q;

endmodule
